// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has combinational priority, secondary word commands queue in a FIFO.
// Optional starvation guard (cpu_hold) is built only when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_cs,
    input  logic                          cpu_r,
    input  logic                          cpu_w,
    input  logic [31:0]                   cpu_addr,
    input  logic [31:0]                   cpu_wdata,
    input  logic [7:0]                    cpu_mode,
    output logic [31:0]                   cpu_rdata,
    output logic                          cpu_hold,
    input  logic                          s_req_valid,
    output logic                          s_req_ready,
    input  logic                          s_req_we,
    input  logic [31:0]                   s_req_addr,
    input  logic [31:0]                   s_req_wdata,
    output logic                          s_rsp_valid,
    output logic [31:0]                   s_rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   s_pending,
    output logic                          m_ena,
    output logic                          m_rena,
    output logic                          m_wena,
    output logic [31:0]                   m_addr,
    output logic [31:0]                   m_wdata,
    output logic [7:0]                    m_mode,
    input  logic [31:0]                   m_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Access-flag bits in {Lbu,Lhu,Lh,Lb,Sb,Sh,Sw,Lw} order.
    localparam logic [7:0] MODE_SW = 8'h02;
    localparam logic [7:0] MODE_LW = 8'h01;

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_CPU  = 2'd1;
    localparam logic [1:0] GNT_SEC  = 2'd2;
    localparam logic [1:0] GNT_HOLD = 2'd3;

    logic              fifo_we    [FIFO_DEPTH];
    logic [31:0]       fifo_addr  [FIFO_DEPTH];
    logic [31:0]       fifo_wdata [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_we;
    logic [31:0]       head_addr;
    logic [31:0]       head_wdata;
    logic [1:0]        grant;
    logic              hold_q;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign s_req_ready = !full && !rst;
    assign push        = s_req_valid && s_req_ready;
    assign s_pending   = count;
    assign cpu_hold    = hold_q;

    assign head_we    = fifo_we[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_wdata[rd_ptr];

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= s_req_we;
            fifo_addr[wr_ptr]  <= s_req_addr;
            fifo_wdata[wr_ptr] <= s_req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        grant = GNT_IDLE;
        if (rst)
            grant = GNT_IDLE;
        else if (hold_q && !empty)
            grant = GNT_HOLD;
        else if (cpu_cs)
            grant = GNT_CPU;
        else if (!empty)
            grant = GNT_SEC;
    end

    assign pop = (grant == GNT_HOLD) || (grant == GNT_SEC);

    // Secondary accesses are always word-aligned; the low two address bits are dropped.
    always_comb begin
        m_ena     = 1'b0;
        m_rena    = 1'b0;
        m_wena    = 1'b0;
        m_addr    = 32'h0;
        m_wdata   = 32'h0;
        m_mode    = 8'h0;
        cpu_rdata = 32'h0;
        case (grant)
            GNT_CPU: begin
                m_ena     = cpu_cs;
                m_rena    = cpu_r;
                m_wena    = cpu_w;
                m_addr    = cpu_addr;
                m_wdata   = cpu_wdata;
                m_mode    = cpu_mode;
                cpu_rdata = m_rdata;
            end
            GNT_SEC, GNT_HOLD: begin
                m_ena   = 1'b1;
                m_wena  = head_we;
                m_rena  = !head_we;
                m_addr  = head_addr & 32'hFFFF_FFFC;
                m_wdata = head_wdata;
                m_mode  = head_we ? MODE_SW : MODE_LW;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rsp_valid <= 1'b0;
            s_rsp_rdata <= 32'h0;
        end else begin
            s_rsp_valid <= pop && !head_we;
            if (pop && !head_we)
                s_rsp_rdata <= m_rdata;
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;

    // The hold lasts a single cycle; the HOLD grant in that cycle empties the counter again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            hold_q   <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            if (empty || pop) begin
                wait_cnt <= '0;
            end else if (cpu_cs && !hold_q && (wait_cnt != WW'(MAX_WAIT))) begin
                wait_cnt <= wait_cnt + WW'(1);
                if (wait_cnt == WW'(MAX_WAIT - 1))
                    hold_q <= 1'b1;
            end
        end
    end
`else
    assign hold_q = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random phase, all checked
// against a queue-based reference model; honours DMEM_ARB_STARVE_EN when it is defined.
module tb_dmem_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXW  = 8;
    localparam int PW    = $clog2(DEPTH) + 1;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cpu_cs, cpu_r, cpu_w;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic [7:0]    cpu_mode;
    logic [31:0]   cpu_rdata;
    logic          cpu_hold;
    logic          s_req_valid, s_req_ready, s_req_we;
    logic [31:0]   s_req_addr, s_req_wdata;
    logic          s_rsp_valid;
    logic [31:0]   s_rsp_rdata;
    logic [PW-1:0] s_pending;
    logic          m_ena, m_rena, m_wena;
    logic [31:0]   m_addr, m_wdata;
    logic [7:0]    m_mode;
    logic [31:0]   m_rdata;

    int n_compared = 0;
    int n_mismatch = 0;

    dmem_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_r(cpu_r), .cpu_w(cpu_w),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mode(cpu_mode),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_pending(s_pending),
        .m_ena(m_ena), .m_rena(m_rena), .m_wena(m_wena),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide dram stand-in covering byte addresses 0..255.
    logic [31:0] dram [64];
    assign m_rdata = dram[m_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dram[i] <= 32'h0;
        end else if (m_ena && m_wena) begin
            dram[m_addr[7:2]] <= m_wdata;
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        q[$];
    logic [31:0] ref_mem [64];
    bit          ref_rsp_valid;
    logic [31:0] ref_rsp_rdata;
    bit          ref_hold;
    int          ref_wait;
    bit          mdl_cpu;
    bit          mdl_issue;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatch++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic r, input logic w, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [7:0] mode, input logic sv,
                                 input logic swe, input logic [31:0] saddr, input logic [31:0] swdata);
        cpu_cs      = cs;
        cpu_r       = r;
        cpu_w       = w;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
        cpu_mode    = mode;
        s_req_valid = sv;
        s_req_we    = swe;
        s_req_addr  = saddr;
        s_req_wdata = swdata;
    endtask

    task automatic modelClear();
        q.delete();
        ref_rsp_valid = 1'b0;
        ref_rsp_rdata = 32'h0;
        ref_hold      = 1'b0;
        ref_wait      = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    endtask

    // Decide this cycle's grant from the priority rules and compare every output.
    task automatic checkAll();
        logic        e_ena, e_rena, e_wena;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [7:0]  e_mode;
        cmd_t        head;
        #1;
        mdl_cpu   = 1'b0;
        mdl_issue = 1'b0;
        if (STARVE && ref_hold && q.size() > 0) mdl_issue = 1'b1;
        else if (cpu_cs)                        mdl_cpu   = 1'b1;
        else if (q.size() > 0)                  mdl_issue = 1'b1;
        e_ena = 0; e_rena = 0; e_wena = 0;
        e_addr = 0; e_wdata = 0; e_rdata = 0; e_mode = 0;
        if (mdl_cpu) begin
            e_ena = 1'b1; e_rena = cpu_r; e_wena = cpu_w;
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_mode = cpu_mode;
            e_rdata = ref_mem[cpu_addr[7:2]];
        end else if (mdl_issue) begin
            head = q[0];
            e_ena = 1'b1; e_wena = head.we; e_rena = !head.we;
            e_addr = {head.addr[31:2], 2'b00}; e_wdata = head.wdata;
            e_mode = head.we ? 8'h02 : 8'h01;
        end
        checkOutput("m_ena", 32'(m_ena), 32'(e_ena));
        checkOutput("m_rena", 32'(m_rena), 32'(e_rena));
        checkOutput("m_wena", 32'(m_wena), 32'(e_wena));
        checkOutput("m_addr", m_addr, e_addr);
        checkOutput("m_wdata", m_wdata, e_wdata);
        checkOutput("m_mode", 32'(m_mode), 32'(e_mode));
        checkOutput("cpu_rdata", cpu_rdata, e_rdata);
        checkOutput("cpu_hold", 32'(cpu_hold), 32'(STARVE && ref_hold));
        checkOutput("s_req_ready", 32'(s_req_ready), 32'(q.size() < DEPTH));
        checkOutput("s_pending", 32'(s_pending), 32'(q.size()));
        checkOutput("s_rsp_valid", 32'(s_rsp_valid), 32'(ref_rsp_valid));
        checkOutput("s_rsp_rdata", s_rsp_rdata, ref_rsp_rdata);
    endtask

    // Advance the model across the clock edge using the inputs that were held through it.
    task automatic modelUpdate();
        int   sz;
        bit   do_push;
        cmd_t head;
        sz      = q.size();
        do_push = s_req_valid && (sz < DEPTH);
        if (mdl_issue) begin
            head = q.pop_front();
            ref_rsp_valid = !head.we;
            if (head.we) ref_mem[head.addr[7:2]] = head.wdata;
            else         ref_rsp_rdata = ref_mem[head.addr[7:2]];
        end else begin
            ref_rsp_valid = 1'b0;
            if (mdl_cpu && cpu_w) ref_mem[cpu_addr[7:2]] = cpu_wdata;
        end
        if (do_push) q.push_back('{we: s_req_we, addr: s_req_addr, wdata: s_req_wdata});
        if (STARVE) begin
            if (sz == 0 || mdl_issue) begin
                ref_wait = 0;
                ref_hold = 1'b0;
            end else if (cpu_cs && !ref_hold) begin
                ref_wait++;
                ref_hold = (ref_wait == MAXW);
            end else begin
                ref_hold = 1'b0;
            end
        end
    endtask

    task automatic runCycle();
        checkAll();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cpuBusySecRead(input logic [31:0] saddr);
        applyStimulus(1, 1, 0, 32'h80, 0, 8'h01, 1, 0, saddr, 0);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_pending", 32'(s_pending), 32'h0);
        checkOutput("rst_rsp_valid", 32'(s_rsp_valid), 32'h0);
        checkOutput("rst_ready", 32'(s_req_ready), 32'h0);
        checkOutput("rst_m_ena", 32'(m_ena), 32'h0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'h0);
        @(posedge clk);
        modelClear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic cs;
        logic rw;
        rst = 1'b1;
        idle();
        modelClear();
        @(negedge clk);
        @(negedge clk);
        checkOutput("init_pending", 32'(s_pending), 32'h0);
        checkOutput("init_ready", 32'(s_req_ready), 32'h0);
        checkOutput("init_rsp_valid", 32'(s_rsp_valid), 32'h0);
        checkOutput("init_rsp_rdata", s_rsp_rdata, 32'h0);
        rst = 1'b0;
        idle();
        runCycle();

        $display("[TB] write then read through the FIFO");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
        runCycle();
        idle();
        #1;
        checkOutput("t1_wena", 32'(m_wena), 32'h1);
        checkOutput("t1_addr", m_addr, 32'h10);
        checkOutput("t1_mode", 32'(m_mode), 32'h02);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h13, 0);
        runCycle();
        idle();
        #1;
        checkOutput("t1_rd_addr", m_addr, 32'h10);
        checkOutput("t1_rd_rena", 32'(m_rena), 32'h1);
        runCycle();
        #1;
        checkOutput("t1_rsp_valid", 32'(s_rsp_valid), 32'h1);
        checkOutput("t1_rsp_rdata", s_rsp_rdata, 32'hDEADBEEF);
        runCycle();
        #1;
        checkOutput("t1_rsp_pulse_end", 32'(s_rsp_valid), 32'h0);

        $display("[TB] fill FIFO while CPU busy, then drain");
        for (int i = 0; i < 4; i++) begin
            cpuBusySecRead(32'h10 + 32'(i) * 4);
            runCycle();
        end
        applyStimulus(1, 1, 0, 32'h80, 0, 8'h01, 0, 0, 0, 0);
        #1;
        checkOutput("t2_ready_low", 32'(s_req_ready), 32'h0);
        checkOutput("t2_pending4", 32'(s_pending), 32'h4);
        runCycle();
        idle();
        for (int i = 0; i < 6; i++) runCycle();

        $display("[TB] CPU byte load beside a queued read");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 32'hA5A51234);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
        runCycle();
        applyStimulus(1, 1, 0, 32'h21, 0, 8'h10, 0, 0, 0, 0);
        #1;
        checkOutput("t3_mode", 32'(m_mode), 32'h10);
        checkOutput("t3_addr", m_addr, 32'h21);
        checkOutput("t3_cpu_rdata", cpu_rdata, 32'hA5A51234);
        runCycle();
        idle();
        #1;
        checkOutput("t3_sec_addr", m_addr, 32'h10);
        checkOutput("t3_sec_rena", 32'(m_rena), 32'h1);
        runCycle();
        runCycle();

        $display("[TB] starvation guard with CPU selecting memory continuously");
        cpuBusySecRead(32'h20);
        runCycle();
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 1, 0, 32'h80, 0, 8'h01, 0, 0, 0, 0);
            #1;
            checkOutput("t4_hold", 32'(cpu_hold), 32'(STARVE && i == 9));
            runCycle();
        end
        idle();
        runCycle();
        runCycle();

        $display("[TB] reset with queued commands and a pending response");
        for (int i = 0; i < 4; i++) begin
            cpuBusySecRead(32'h20);
            runCycle();
        end
        idle();
        runCycle();
        #1;
        checkOutput("t5_pre_rsp", 32'(s_rsp_valid), 32'h1);
        checkOutput("t5_pre_pending", 32'(s_pending), 32'h3);
        doReset();
        for (int i = 0; i < 3; i++) runCycle();

        $display("[TB] push and pop together at occupancy 2");
        cpuBusySecRead(32'h10);
        runCycle();
        cpuBusySecRead(32'h14);
        runCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 255)), $urandom);
            #1;
            checkOutput("t6_pending2", 32'(s_pending), 32'h2);
            runCycle();
        end
        idle();
        for (int i = 0; i < 3; i++) runCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            cs = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 55 : 92));
            rw = 1'($urandom_range(0, 1));
            applyStimulus(cs, cs && !rw, cs && rw, 32'($urandom_range(0, 255)), $urandom,
                          8'(1 << $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
            runCycle();
        end
        idle();
        for (int i = 0; i < 6; i++) runCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory port (`dram`) between the CPU and one secondary word-access requester (debug loader / DMA). The CPU always has priority and passes through combinationally. Secondary requests are buffered in a small command FIFO and issued in cycles where the CPU does not select memory. An optional starvation guard can freeze the CPU for one cycle to force a secondary issue. The block sits between `cpu`, the secondary master and `dmem` in `sccomp_dataflow`, clocked by the divided CPU clock.

## Interface
- FIFO_DEPTH, 4, secondary command FIFO entries; power of two, ≥2
- MAX_WAIT, 8, blocked cycles before starvation hold; ≥1; used only with guard enabled
- clk  in  1  CPU clock (divided clock); all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_cs, cpu_r, cpu_w  in  1 each  CPU DM_CS / DM_R / DM_W
- cpu_addr, cpu_wdata  in  32 each  CPU address / store data
- cpu_mode  in  8  CPU access flags {Lbu,Lhu,Lh,Lb,Sb,Sh,Sw,Lw}
- cpu_rdata  out  32  load data to CPU
- cpu_hold  out  1  CPU clock-enable freeze (starvation guard)
- s_req_valid  in  1  secondary command valid
- s_req_ready  out  1  FIFO can accept
- s_req_we  in  1  1 = word write, 0 = word read
- s_req_addr, s_req_wdata  in  32 each  byte address / write data
- s_rsp_valid  out  1  read data valid, one-cycle pulse
- s_rsp_rdata  out  32  read data
- s_pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- m_ena, m_rena, m_wena  out  1 each  to dram ena / rena / wena
- m_addr, m_wdata  out  32 each  to dram
- m_mode  out  8  to dram access flags, same order as cpu_mode
- m_rdata  in  32  dram dataout (combinational read)

## Operation
- FIFO: push on s_req_valid && s_req_ready, storing {we, addr, wdata}. s_req_ready = !full && !rst. No bypass: a push into an empty FIFO issues no earlier than the next cycle. Simultaneous push and pop when full is impossible because ready is low; when not full, both take effect and occupancy is unchanged.
- Grant is combinational each cycle, in priority order:
  1. HOLD: cpu_hold=1 and FIFO non-empty. Issue the FIFO head; ignore cpu_*; cpu_rdata=0.
  2. CPU: cpu_cs=1. All m_* mirror cpu_* directly; cpu_rdata=m_rdata.
  3. SEC: FIFO non-empty. Issue the head.
  4. IDLE: all m_* = 0, cpu_rdata=0.
- Secondary issue drives:
  - m_ena=1, m_wena=we, m_rena=!we
  - m_addr = {addr[31:2], 2'b00}
  - m_wdata = wdata
  - m_mode = we ? Sw only : Lw only
  - The head is popped at the clock edge.
- Read issue: m_rdata is registered into s_rsp_rdata, and s_rsp_valid=1 for exactly the following cycle. Writes produce no response. Responses return in issue order; at most one issue occurs per cycle.
- Starvation counter wait_cnt (0..MAX_WAIT):
  - increments when FIFO is non-empty, cpu_cs=1 and cpu_hold=0
  - clears on any secondary issue or when the FIFO is empty
  - cpu_hold (registered) is set at the edge where wait_cnt becomes MAX_WAIT
  - cpu_hold is cleared at the next edge, so it is high for exactly one cycle, during which the head issues.

## Timing
- Reset values: s_rsp_valid=0, s_rsp_rdata=0, cpu_hold=0, s_pending=0, FIFO empty, wait_cnt=0. s_req_ready=0 while rst=1. Combinational m_* outputs are 0 in reset.
- Reset mid-operation: queued commands are discarded, and any pending response pulse is cancelled.
- CPU path latency: 0 cycles (combinational).
- Secondary path:
  - earliest issue is 1 cycle after the push edge
  - read response follows 1 cycle after the issue cycle
  - minimum request-to-response is 2 cycles
- Back-to-back secondary reads in free cycles yield consecutive s_rsp_valid pulses.
- m_wena is only ever asserted during a granted cycle; the dram samples the write on the rising edge ending that cycle.

## Configuration
- Macro: DMEM_ARB_STARVE_EN.
- Defined: the starvation counter and cpu_hold operate as specified above.
- Undefined:
  - no counter is built and cpu_hold is tied 0
  - the HOLD grant never occurs
  - secondary commands wait indefinitely while cpu_cs stays high
  - MAX_WAIT is ignored

## Test plan
- After reset release with an idle CPU, push a write (addr 0x10, data 0xDEADBEEF). Required: m_wena=1, m_addr=0x10, m_mode=Sw the next cycle. Then push a read of 0x13. Required: m_addr=0x10, and s_rsp_rdata=0xDEADBEEF with s_rsp_valid high for one cycle, 2 cycles after the push.
- Hold cpu_cs=1 while pushing 4 reads. Required: s_req_ready falls after the 4th push, s_pending=4, and no secondary issue occurs. Drop cpu_cs: reads issue on 4 consecutive cycles, giving 4 response pulses in order.
- CPU lb at 0x21 in the same cycle as a queued secondary read. Required: m_mode=Lb flag, m_addr=0x21, cpu_rdata=m_rdata. The secondary read issues the first cycle cpu_cs=0.
- With DMEM_ARB_STARVE_EN and MAX_WAIT=8: cpu_cs=1 continuously with one queued read. Required: cpu_hold=1 in cycle 9 only, the head issues that cycle, and cpu_rdata=0 in that cycle. Without the macro, cpu_hold stays 0 and no issue occurs.
- Assert rst with 3 queued commands and a response pending. Required: s_pending=0, s_rsp_valid=0, s_req_ready=0 immediately (asynchronous). After release, no stale issue occurs.
- Push and pop in the same cycle with FIFO occupancy 2. Required: s_pending stays 2 and the FIFO pointer wraps correctly over 10 such cycles.
